// File: rtl/ecc_decode_ctrl.sv
`timescale 1ns/1ps
// ecc_decode_ctrl: walks NUM_WORDS SECDED-encoded 16-bit codewords in data memory,
// corrects single errors, flags double errors and writes data plus status back.
module ecc_decode_ctrl #(
    parameter int NUM_WORDS = 15,
    parameter int SRC_BASE  = 30,
    parameter int DST_BASE  = 0
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Start,
    output logic       Busy,
    output logic       Done,
    output logic [7:0] MemAddr,
    input  logic [7:0] MemRdData,
    output logic       MemWrEn,
    output logic [7:0] MemWrData,
    output logic [7:0] Err1Cnt,
    output logic [7:0] Err2Cnt
);

    typedef enum logic [2:0] {IDLE, RDL, RDM, LATM, FIX, WRL, WRM, DONE} state_t;

    localparam logic [7:0] SRC_B    = 8'(SRC_BASE);
    localparam logic [7:0] DST_B    = 8'(DST_BASE);
    localparam logic [5:0] LAST_IDX = 6'(NUM_WORDS - 1);

    state_t      r_state, w_next;
    logic [5:0]  r_idx;
    logic [7:0]  r_lsw, r_msw;
    logic        r_fix_phase;
    logic [3:0]  r_syn;
    logic        r_gpar;
    logic [10:0] r_data;
    logic [1:0]  r_flags;
    logic [7:0]  r_err1, r_err2;

    logic [15:0] w_code;
    logic [3:0]  w_syn;
    logic        w_gpar;
    logic [10:0] w_dflip;
    logic [10:0] w_data;
    logic [1:0]  w_flags;
    logic [7:0]  w_offset;

    assign w_offset = {1'b0, r_idx, 1'b0};
    assign Err1Cnt  = r_err1;
    assign Err2Cnt  = r_err2;

    // NOTE: sequential state uses non-blocking assignments so all registers sample pre-edge values.
    always_ff @(posedge Clk) begin
        if (!Reset) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (Start) w_next = RDL;
            RDL:     w_next = RDM;
            RDM:     w_next = LATM;
            LATM:    w_next = FIX;
            FIX:     w_next = r_fix_phase ? WRL : FIX;
            WRL:     w_next = WRM;
            WRM:     w_next = (r_idx == LAST_IDX) ? DONE : RDL;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // FIX spends two cycles: syndrome is registered first, correction applied second.
    always_comb begin
        w_code   = {r_msw, r_lsw};
        w_syn[0] = ^(w_code & 16'hAAAA);
        w_syn[1] = ^(w_code & 16'hCCCC);
        w_syn[2] = ^(w_code & 16'hF0F0);
        w_syn[3] = ^(w_code & 16'hFF00);
        w_gpar   = ^w_code;
    end

    // NOTE: every comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_dflip = '0;
        case (r_syn)
            4'd3:    w_dflip = 11'h001;
            4'd5:    w_dflip = 11'h002;
            4'd6:    w_dflip = 11'h004;
            4'd7:    w_dflip = 11'h008;
            4'd9:    w_dflip = 11'h010;
            4'd10:   w_dflip = 11'h020;
            4'd11:   w_dflip = 11'h040;
            4'd12:   w_dflip = 11'h080;
            4'd13:   w_dflip = 11'h100;
            4'd14:   w_dflip = 11'h200;
            4'd15:   w_dflip = 11'h400;
            default: w_dflip = '0;
        endcase
        w_flags = 2'b00;
        w_data  = {w_code[15:9], w_code[7:5], w_code[3]};
        if (r_gpar) begin
            w_flags = 2'b01;
            w_data  = w_data ^ w_dflip;
        end else if (r_syn != 4'd0) begin
            w_flags = 2'b10;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            r_idx       <= '0;
            r_lsw       <= '0;
            r_msw       <= '0;
            r_fix_phase <= 1'b0;
            r_syn       <= '0;
            r_gpar      <= 1'b0;
            r_data      <= '0;
            r_flags     <= '0;
            r_err1      <= '0;
            r_err2      <= '0;
        end else begin
            case (r_state)
                IDLE: if (Start) begin
                    r_idx  <= '0;
                    r_err1 <= '0;
                    r_err2 <= '0;
                end
                RDM:  r_lsw <= MemRdData;
                LATM: r_msw <= MemRdData;
                FIX: begin
                    r_fix_phase <= ~r_fix_phase;
                    if (!r_fix_phase) begin
                        r_syn  <= w_syn;
                        r_gpar <= w_gpar;
                    end else begin
                        r_data  <= w_data;
                        r_flags <= w_flags;
                        if (w_flags[0] && r_err1 != 8'hFF) r_err1 <= r_err1 + 8'd1;
                        if (w_flags[1] && r_err2 != 8'hFF) r_err2 <= r_err2 + 8'd1;
                    end
                end
                WRM:  if (r_idx != LAST_IDX) r_idx <= r_idx + 6'd1;
                default: ;
            endcase
        end
    end

    // Write strobe is qualified by Reset so a reset landing on a write edge stores nothing.
    always_comb begin
        Busy      = (r_state != IDLE) && (r_state != DONE);
        Done      = (r_state == DONE);
        MemAddr   = '0;
        MemWrEn   = 1'b0;
        MemWrData = '0;
        case (r_state)
            RDL: MemAddr = SRC_B + w_offset;
            RDM: MemAddr = SRC_B + w_offset + 8'd1;
            WRL: begin
                MemWrEn   = Reset;
                MemAddr   = DST_B + w_offset;
                MemWrData = r_data[7:0];
            end
            WRM: begin
                MemWrEn   = Reset;
                MemAddr   = DST_B + w_offset + 8'd1;
                MemWrData = {r_flags, 3'b000, r_data[10:8]};
            end
            default: ;
        endcase
    end

endmodule

// File: doc/ecc_decode_ctrl.md
ECC_DECODE_CTRL -- requirements
Module: ecc_decode_ctrl

Interface
REQ-001 SHALL have parameter NUM_WORDS, default 15, the number of codewords decoded per run (1..64).
REQ-002 SHALL have parameter SRC_BASE, default 30, the data-memory byte address of the first encoded LSW.
REQ-003 SHALL have parameter DST_BASE, default 0, the data-memory byte address of the first decoded LSW.
REQ-004 SHALL have port Clk  input  1  the single clock; all state changes on its rising edge.
REQ-005 SHALL have port Reset  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port Start  input  1  run request, sampled in IDLE only.
REQ-007 SHALL have port Busy  output  1  high from the cycle after Start is accepted until Done.
REQ-008 SHALL have port Done  output  1  one-cycle pulse at the end of a run.
REQ-009 SHALL have port MemAddr  output  8  data-memory byte address.
REQ-010 SHALL have port MemRdData  input  8  read data, valid one cycle after MemAddr is driven.
REQ-011 SHALL have port MemWrEn  output  1  write strobe; write of MemWrData to MemAddr at the clock edge.
REQ-012 SHALL have port MemWrData  output  8  write data.
REQ-013 SHALL have port Err1Cnt  output  8  count of corrected single errors in the current or last run.
REQ-014 SHALL have port Err2Cnt  output  8  count of detected double errors in the current or last run.

Function
REQ-015 SHALL implement states IDLE, RDL, RDM, LATM, FIX, WRL, WRM, DONE.
REQ-016 IDLE: Start=1 -> RDL, word index i=0, Err1Cnt=Err2Cnt=0; otherwise stay.
REQ-017 RDL: MemAddr=SRC_BASE+2i -> RDM.
REQ-018 RDM: MemAddr=SRC_BASE+2i+1, latch MemRdData as LSW -> LATM.
REQ-019 LATM: latch MemRdData as MSW -> FIX.
REQ-020 FIX: form c[15:0]={MSW,LSW}; parity bits at positions 0,1,2,4,8; data d1..d11 at positions 3,5,6,7,9..15 -> WRL.
REQ-021 Syndrome bit j (j=0..3) SHALL be XOR of all c[k], k=1..15, with bit j of k set; G = XOR of all 16 bits of c.
REQ-022 S=0,G=0: no error, flags 00. S!=0,G=1: flip c[S], flags 01, Err1Cnt+1. S=0,G=1: p0 error, data unchanged, flags 01, Err1Cnt+1. S!=0,G=0: double error, no correction, flags 10, Err2Cnt+1.
REQ-023 Counters SHALL saturate at 8'hFF.
REQ-024 WRL: MemWrEn=1, MemAddr=DST_BASE+2i, MemWrData={d8..d1} -> WRM.
REQ-025 WRM: MemWrEn=1, MemAddr=DST_BASE+2i+1, MemWrData={flags[1:0],3'b000,d11,d10,d9}; i=NUM_WORDS-1 -> DONE, else i+1 and -> RDL.
REQ-026 DONE: Done=1 for exactly one cycle -> IDLE; Busy=0 in DONE and IDLE.
REQ-027 Per-codeword latency SHALL be 7 cycles; a run SHALL take 7*NUM_WORDS+1 cycles from Start acceptance to Done.
REQ-028 Start while Busy SHALL be ignored; Start held high through DONE SHALL begin a new run from the next IDLE cycle.
REQ-029 MemWrEn SHALL be 0 in all states except WRL and WRM; MemAddr SHALL be 0 in IDLE and DONE.
REQ-030 Err1Cnt/Err2Cnt SHALL hold their final values after Done until the next accepted Start.

Reset
REQ-031 Reset=0 at a clock edge SHALL force IDLE, i=0, Busy=0, Done=0, MemWrEn=0, MemAddr=0, MemWrData=0, Err1Cnt=0, Err2Cnt=0, regardless of state.
REQ-032 Reset mid-run SHALL abort with no further writes; a partially written codeword pair is not repaired.

Verification
REQ-033 Clean: source word 16'hFFFF -> LSW 8'hFF, MSW 8'h07, counts 0/0.
REQ-034 Single data error: 16'hFFDF (c5 flipped) -> LSW 8'hFF, MSW 8'h47, Err1Cnt=1.
REQ-035 p0-only error: 16'hFFFE -> LSW 8'hFF, MSW 8'h47, Err1Cnt=1.
REQ-036 Double error: 16'hFFCF (c4,c5 flipped) -> LSW 8'hFD, MSW 8'h87, Err2Cnt=1.
REQ-037 Full run NUM_WORDS=15 of 16'h0000 -> all 30 destination bytes 8'h00, Done exactly 106 cycles after Start accepted, Start pulses during Busy ignored.
REQ-038 Reset=0 asserted in WRL of word 3 -> next cycle IDLE, MemWrEn=0, counters 0, destination bytes of word 3 onward untouched.
